// File: rtl/snes_controller_reader.sv
// SNES gamepad serial reader: drives latch/clock at a fixed poll rate,
// shifts in the 16-bit word and publishes registered active-low buttons.
//
// Ports:
//   CLK, RST_N         clock, async active-low reset
//   SNES_DATA          serial data from pad (async, active-low)
//   SNES_LATCH         latch pulse to pad
//   SNES_CLK           data clock to pad, idles high
//   B..R               12 button levels, 0 = pressed
//   VALID              last frame carried ID nibble 4'b1111
//   FRAME_DONE         one-cycle pulse when buttons update
module snes_controller_reader #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SNES_DATA,
  output logic SNES_LATCH,
  output logic SNES_CLK,
  output logic B,
  output logic Y,
  output logic Select,
  output logic Start,
  output logic Up,
  output logic Down,
  output logic Left,
  output logic Right,
  output logic A,
  output logic X,
  output logic L,
  output logic R,
  output logic VALID,
  output logic FRAME_DONE
);

  localparam int PW =
    (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW =
    (2 * HALF_CYCLES > 1) ? $clog2(2 * HALF_CYCLES) : 1;

  localparam logic [PW-1:0] POLL_LAST =
    PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST =
    TW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LAST =
    TW'(2 * HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    UPDATE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   poll_cnt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic [3:0]      idx;
  logic [3:0]      idx_n;
  logic            data_s1;
  logic            data_s2;
  logic [15:0]     shift;
  logic [11:0]     btn;
  logic            wrap;
  logic            capture;

  assign wrap = (poll_cnt == POLL_LAST);

  // timer counts cycles spent in the current state
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (wrap) state_n = LATCH;
      end
      LATCH: begin
        if (timer == LATCH_LAST) begin
          state_n = CLK_LOW;
          timer_n = '0;
          idx_n   = '0;
        end
      end
      CLK_LOW: begin
        if (timer == HALF_LAST) begin
          capture = 1'b1;
          state_n = CLK_HIGH;
          timer_n = '0;
        end
      end
      CLK_HIGH: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          if (idx == 4'd15) begin
            state_n = UPDATE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = CLK_LOW;
          end
        end
      end
      UPDATE: begin
        timer_n = '0;
        state_n = IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      poll_cnt <= '0;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      idx      <= idx_n;
      poll_cnt <= wrap ? '0 : poll_cnt + 1'b1;
      data_s1  <= SNES_DATA;
      data_s2  <= data_s1;
    end
  end

  // pad outputs registered from next state so they
  // change on the same edge as the state itself
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SNES_LATCH <= 1'b0;
      SNES_CLK   <= 1'b1;
    end else begin
      SNES_LATCH <= (state_n == LATCH);
      SNES_CLK   <= (state_n != CLK_LOW);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift      <= '1;
      btn        <= '1;
      VALID      <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      if (capture) shift[idx] <= data_s2;
      FRAME_DONE <= (state == UPDATE);
      if (state == UPDATE) begin
        // a missing pad or stuck-low line fails the ID nibble
        if (&shift[15:12]) begin
          btn   <= shift[11:0];
          VALID <= 1'b1;
        end else begin
          btn   <= '1;
          VALID <= 1'b0;
        end
      end
    end
  end

  assign B      = btn[0];
  assign Y      = btn[1];
  assign Select = btn[2];
  assign Start  = btn[3];
  assign Up     = btn[4];
  assign Down   = btn[5];
  assign Left   = btn[6];
  assign Right  = btn[7];
  assign A      = btn[8];
  assign X      = btn[9];
  assign L      = btn[10];
  assign R      = btn[11];

endmodule

// File: tb/tb_snes_controller_reader.sv
// Bench for snes_controller_reader: pad model, timing monitor,
// directed vector table, reset-mid-frame and random frames.
module tb_snes_controller_reader;

  localparam int HALF = 4;
  localparam int POLL = 200;
  localparam int LAT  = 34 * HALF + 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SNES_DATA = 1'b1;
  logic SNES_LATCH, SNES_CLK;
  logic B, Y, Select, Start, Up, Down;
  logic Left, Right, A, X, L, R;
  logic VALID, FRAME_DONE;
  logic [11:0] btns;

  snes_controller_reader #(
    .HALF_CYCLES(HALF),
    .POLL_CYCLES(POLL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_DATA(SNES_DATA),
    .SNES_LATCH(SNES_LATCH), .SNES_CLK(SNES_CLK),
    .B(B), .Y(Y), .Select(Select), .Start(Start),
    .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .A(A), .X(X), .L(L), .R(R),
    .VALID(VALID), .FRAME_DONE(FRAME_DONE)
  );

  assign btns = {R, L, X, A, Right, Left, Down, Up,
                 Start, Select, Y, B};

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(input string name,
                              input int act,
                              input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  function automatic void ref_model(
    input  logic [15:0] w,
    output logic [11:0] b,
    output logic        v);
    v = (w[15:12] == 4'hF);
    b = v ? w[11:0] : 12'hFFF;
  endfunction

  // cycle index: number of rising edges since reset release
  int cyc = 0;
  always @(posedge CLK)
    if (!RST_N) cyc <= 0;
    else cyc <= cyc + 1;

  // pad model + timing monitor, evaluated mid-cycle
  logic [15:0] ctrl_word = 16'hFFFF;
  int bitpos = 16;
  int last_rise = 0, prev_rise = 0;
  int latch_w = 0, lows = 0, bad_low = 0;
  int low_start = 0, unstable = 0, edge_bad = 0;
  logic pl = 1'b0, pc = 1'b1;
  logic [11:0] pbm = 12'hFFF;
  logic pvm = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      last_rise = 0; prev_rise = 0; latch_w = 0;
      lows = 0; bad_low = 0; low_start = 0;
    end else begin
      if (SNES_LATCH && !pl) begin
        prev_rise = last_rise;
        last_rise = cyc;
        lows = 0;
        bad_low = 0;
      end
      if (!SNES_LATCH && pl) begin
        latch_w = cyc - last_rise;
        if (SNES_CLK) edge_bad++;
      end
      if (!SNES_CLK && pc) low_start = cyc;
      if (SNES_CLK && !pc) begin
        lows++;
        if (cyc - low_start != HALF) bad_low++;
      end
      if (!FRAME_DONE && (btns != pbm || VALID != pvm))
        unstable++;
    end
    if (SNES_LATCH) bitpos = 0;
    else if (SNES_CLK && !pc) bitpos++;
    SNES_DATA = (bitpos < 16) ? ctrl_word[bitpos] : 1'b1;
    pl = SNES_LATCH;
    pc = SNES_CLK;
    pbm = btns;
    pvm = VALID;
  end

  logic [11:0] exp_btn = 12'hFFF;
  logic        exp_valid = 1'b0;

  task automatic do_frame(input logic [15:0] w,
                          input logic [11:0] eb,
                          input logic        ev);
    logic [11:0] pb;
    logic        pv;
    bit          got;
    ctrl_word = w;
    got = 0;
    pb = btns;
    pv = VALID;
    for (int i = 0; i < 2 * POLL && !got; i++) begin
      @(negedge CLK); #1;
      if (FRAME_DONE) got = 1;
      else begin pb = btns; pv = VALID; end
    end
    chk("done_seen", int'(got), 1);
    if (got) begin
      chk("buttons", int'(btns), int'(eb));
      chk("valid", int'(VALID), int'(ev));
      chk("hold_buttons", int'(pb), int'(exp_btn));
      chk("hold_valid", int'(pv), int'(exp_valid));
      chk("latency", cyc - last_rise, LAT);
      chk("poll_period", last_rise - prev_rise, POLL);
      chk("latch_width", latch_w, 2 * HALF);
      chk("low_pulses", lows, 16);
      chk("low_width_bad", bad_low, 0);
      @(negedge CLK); #1;
      chk("done_one_cycle", int'(FRAME_DONE), 0);
    end
    exp_btn = eb;
    exp_valid = ev;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] btn;
    logic        valid;
  } vec_t;

  vec_t tab[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    logic [11:0] eb;
    logic        ev;
    bit          seen;

    tab[0] = '{16'hFEFF, 12'hEFF, 1'b1};
    tab[1] = '{16'hFFF6, 12'hFF6, 1'b1};
    tab[2] = '{16'h0000, 12'hFFF, 1'b0};
    tab[3] = '{16'hFFFD, 12'hFFD, 1'b1};
    tab[4] = '{16'h7FFF, 12'hFFF, 1'b0};
    tab[5] = '{16'hFFFE, 12'hFFE, 1'b1};
    tab[6] = '{16'hFDFF, 12'hDFF, 1'b1};
    tab[7] = '{16'hFFFF, 12'hFFF, 1'b1};
    tab[8] = '{16'hFEFF, 12'hEFF, 1'b1};

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_buttons", int'(btns), 12'hFFF);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_done", int'(FRAME_DONE), 0);
    chk("rst_latch", int'(SNES_LATCH), 0);
    chk("rst_clk", int'(SNES_CLK), 1);
    @(negedge CLK); #2;
    RST_N = 1'b1;

    for (int i = 0; i < 9; i++)
      do_frame(tab[i].word, tab[i].btn, tab[i].valid);

    ctrl_word = 16'hFFFF;
    seen = 0;
    for (int i = 0; i < 2 * POLL && !seen; i++) begin
      @(negedge CLK); #1;
      if (SNES_LATCH) seen = 1;
    end
    chk("latch_seen", int'(seen), 1);
    repeat (58) @(negedge CLK);
    #1;
    chk("pre_rst_clk_low", int'(SNES_CLK), 0);
    chk("pre_rst_a", int'(A), 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_latch", int'(SNES_LATCH), 0);
    chk("mid_rst_clk", int'(SNES_CLK), 1);
    chk("mid_rst_a", int'(A), 1);
    chk("mid_rst_valid", int'(VALID), 0);
    chk("mid_rst_done", int'(FRAME_DONE), 0);
    exp_btn = 12'hFFF;
    exp_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    do_frame(16'hFFFB, 12'hFFB, 1'b1);

    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) != 0) w[15:12] = 4'hF;
      ref_model(w, eb, ev);
      do_frame(w, eb, ev);
    end

    chk("outputs_stable", unstable, 0);
    chk("clk_falls_with_latch", edge_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
